// File: rtl/axi_arb_chk_pkg.sv
// Shared types and constants for the AW arbiter checker.
package axi_arb_chk_pkg;

    // Arbitration mode selected at runtime by arb_mode.
    typedef enum logic [1:0] {
        FIXED = 2'd0,
        RR    = 2'd1,
        WRR   = 2'd2,
        RSVD  = 2'd3
    } arb_mode_e;

    // Error status bit positions; lower index means higher capture priority.
    localparam int ERR_W     = 8;
    localparam int ERR_MULTI = 0;
    localparam int ERR_NOARB = 1;
    localparam int ERR_PRIO  = 2;
    localparam int ERR_RR    = 3;
    localparam int ERR_WRR   = 4;
    localparam int ERR_MODE  = 5;
    localparam int ERR_STARV = 6;
    localparam int ERR_PROTO = 7;

    typedef logic [2:0] err_code_t;

    // Index of the lowest set error bit (0 when none are set).
    function automatic err_code_t lowest_err(input logic [ERR_W-1:0] bits);
        lowest_err = '0;
        for (int k = ERR_W - 1; k >= 0; k--) begin
            if (bits[k]) begin
                lowest_err = err_code_t'(k);
            end
        end
    endfunction

endpackage

// File: rtl/axi_arb_chk_chan.sv
// Per-channel state for the AW arbiter checker: consecutive-grant run
// counter, wait counter, registered valid and handshake, plus the
// channel-local STARVE and PROTO flags.
module axi_arb_chk_chan
    import axi_arb_chk_pkg::*;
#(
    parameter int CNT_W    = 17,
    parameter int STARVE_W = 12
) (
    input  logic                aclk,
    input  logic                areset_n,
    input  logic                arb_en_i,
    input  logic                awvalid_i,
    input  logic                awready_i,
    input  logic                hs_other_i,
    input  logic [STARVE_W-1:0] starve_limit_i,
    output logic [CNT_W-1:0]    run_cnt_o,
    output logic                vdly_o,
    output logic                starve_o,
    output logic                proto_o
);

    logic                hs;
    logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
    logic [STARVE_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                vdly_q;
    logic                hsdly_q;

    assign hs = awvalid_i & awready_i;

    // Next run count: own grant extends the run, any other grant ends it.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (hs && arb_en_i) begin
            if (run_cnt_q != '1) begin
                run_cnt_d = run_cnt_q + 1'b1;
            end
        end else if (hs_other_i) begin
            run_cnt_d = '0;
        end
    end

    // Next wait count: counts cycles stalled with valid high, saturating.
    always_comb begin
        wait_cnt_d = '0;
        if (awvalid_i && !awready_i) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            run_cnt_q  <= '0;
            wait_cnt_q <= '0;
            vdly_q     <= 1'b0;
            hsdly_q    <= 1'b0;
        end else begin
            run_cnt_q  <= run_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            vdly_q     <= awvalid_i;
            hsdly_q    <= hs;
        end
    end

    assign run_cnt_o = run_cnt_q;
    assign vdly_o    = vdly_q;
    // The count passes the threshold after one cycle, so this fires once per
    // wait episode unless it saturates exactly at the threshold.
    assign starve_o  = (starve_limit_i != '0) && (wait_cnt_q == starve_limit_i);
    // Valid was withdrawn without the previous cycle completing a handshake.
    assign proto_o   = vdly_q && !awvalid_i && !hsdly_q;

endmodule

// File: rtl/axi_arb_chk.sv
// N-channel AW arbiter checker: cross-channel grant rules, sticky error
// status, first-error capture and interrupt pulse. Observes only.
module axi_arb_chk
    import axi_arb_chk_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int CNT_W    = 17,
    parameter int WEIGHT_W = 16,
    parameter int RR_MAX   = 2,
    parameter int STARVE_W = 12,
    parameter int TS_W     = 32
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    input  logic                       arb_en,
    input  logic [1:0]                 arb_mode,
    input  logic [NUM_CH*WEIGHT_W-1:0] weight,
    input  logic [STARVE_W-1:0]        starve_limit,
    input  logic [NUM_CH-1:0]          awvalid,
    input  logic [NUM_CH-1:0]          awready,
    input  logic                       clear_err,
    output logic [ERR_W-1:0]           err_status,
    output logic                       err_any,
    output logic                       err_irq,
    output logic [2:0]                 first_code,
    output logic [$clog2(NUM_CH)-1:0]  first_chan,
    output logic [TS_W-1:0]            first_ts,
    output logic                       first_vld
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int MAX_W = (CNT_W > WEIGHT_W) ? CNT_W : WEIGHT_W;

    arb_mode_e         mode;
    logic              mode_fixed, mode_rr, mode_wrr;
    logic [NUM_CH-1:0] hs, vdly, noarb_v;
    logic [NUM_CH-1:0] prio_c, rr_c, wrr_c, starve_c, proto_c;
    logic [CNT_W-1:0]  run_cnt [NUM_CH];

    logic [ERR_W-1:0]  new_bits;
    logic [CH_W-1:0]   bit_chan [ERR_W];
    err_code_t         new_code;

    logic [ERR_W-1:0]  err_status_q, err_status_d;
    logic              err_irq_q, err_irq_d;
    err_code_t         first_code_q, first_code_d;
    logic [CH_W-1:0]   first_chan_q, first_chan_d;
    logic [TS_W-1:0]   first_ts_q, first_ts_d;
    logic              first_vld_q, first_vld_d;
    logic [TS_W-1:0]   ts_q;

    // Lowest set index of a channel vector (0 when empty).
    function automatic logic [CH_W-1:0] low_idx(input logic [NUM_CH-1:0] v);
        low_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (v[k]) begin
                low_idx = CH_W'(k);
            end
        end
    endfunction

    assign mode       = arb_mode_e'(arb_mode);
    assign mode_fixed = arb_en && (mode == FIXED);
    assign mode_rr    = arb_en && (mode == RR);
    assign mode_wrr   = arb_en && (mode == WRR);
    assign hs         = awvalid & awready;
    assign noarb_v    = {hs[NUM_CH-1:1], 1'b0};

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [NUM_CH-1:0] SELF  = {{(NUM_CH-1){1'b0}}, 1'b1} << gi;
        localparam logic [NUM_CH-1:0] LOWER = SELF - 1'b1;

        logic                hs_other;
        logic                vdly_other;
        logic [WEIGHT_W-1:0] w;

        assign hs_other   = |(hs & ~SELF);
        assign vdly_other = |(vdly & ~SELF);
        assign w          = weight[gi*WEIGHT_W +: WEIGHT_W];

        axi_arb_chk_chan #(
            .CNT_W    (CNT_W),
            .STARVE_W (STARVE_W)
        ) u_chan (
            .aclk           (aclk),
            .areset_n       (areset_n),
            .arb_en_i       (arb_en),
            .awvalid_i      (awvalid[gi]),
            .awready_i      (awready[gi]),
            .hs_other_i     (hs_other),
            .starve_limit_i (starve_limit),
            .run_cnt_o      (run_cnt[gi]),
            .vdly_o         (vdly[gi]),
            .starve_o       (starve_c[gi]),
            .proto_o        (proto_c[gi])
        );

        // A grant is out of priority order if any lower index is requesting.
        assign prio_c[gi] = mode_fixed && hs[gi] && |(awvalid & LOWER);
        // Run count is the number of grants already taken before this one.
        assign rr_c[gi]   = mode_rr && hs[gi] && vdly_other &&
                            (run_cnt[gi] >= CNT_W'(RR_MAX));
        assign wrr_c[gi]  = mode_wrr && hs[gi] && vdly_other &&
                            (MAX_W'(run_cnt[gi]) > MAX_W'(w));
    end

    assign new_bits[ERR_MULTI] = (hs & (hs - 1'b1)) != '0;
    assign new_bits[ERR_NOARB] = !arb_en && (noarb_v != '0);
    assign new_bits[ERR_PRIO]  = |prio_c;
    assign new_bits[ERR_RR]    = |rr_c;
    assign new_bits[ERR_WRR]   = |wrr_c;
    assign new_bits[ERR_MODE]  = arb_en && (mode == RSVD);
    assign new_bits[ERR_STARV] = |starve_c;
    assign new_bits[ERR_PROTO] = |proto_c;

    assign bit_chan[ERR_MULTI] = low_idx(hs);
    assign bit_chan[ERR_NOARB] = low_idx(noarb_v);
    assign bit_chan[ERR_PRIO]  = low_idx(prio_c);
    assign bit_chan[ERR_RR]    = low_idx(rr_c);
    assign bit_chan[ERR_WRR]   = low_idx(wrr_c);
    assign bit_chan[ERR_MODE]  = '0;
    assign bit_chan[ERR_STARV] = low_idx(starve_c);
    assign bit_chan[ERR_PROTO] = low_idx(proto_c);

    assign new_code = lowest_err(new_bits);

    // Sticky status, interrupt and first-error capture; a violation in the
    // same cycle as clear_err wins over the clear.
    always_comb begin
        err_status_d = (clear_err ? '0 : err_status_q) | new_bits;
        err_irq_d    = |(new_bits & ~err_status_q);
        first_code_d = first_code_q;
        first_chan_d = first_chan_q;
        first_ts_d   = first_ts_q;
        first_vld_d  = first_vld_q;
        if ((!first_vld_q || clear_err) && (new_bits != '0)) begin
            first_code_d = new_code;
            first_chan_d = bit_chan[new_code];
            first_ts_d   = ts_q;
            first_vld_d  = 1'b1;
        end else if (clear_err) begin
            first_code_d = '0;
            first_chan_d = '0;
            first_ts_d   = '0;
            first_vld_d  = 1'b0;
        end
    end

    // Status, capture and timestamp registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            err_status_q <= '0;
            err_irq_q    <= 1'b0;
            first_code_q <= '0;
            first_chan_q <= '0;
            first_ts_q   <= '0;
            first_vld_q  <= 1'b0;
            ts_q         <= '0;
        end else begin
            err_status_q <= err_status_d;
            err_irq_q    <= err_irq_d;
            first_code_q <= first_code_d;
            first_chan_q <= first_chan_d;
            first_ts_q   <= first_ts_d;
            first_vld_q  <= first_vld_d;
            ts_q         <= ts_q + 1'b1;
        end
    end

    assign err_status = err_status_q;
    assign err_any    = |err_status_q;
    assign err_irq    = err_irq_q;
    assign first_code = first_code_q;
    assign first_chan = first_chan_q;
    assign first_ts   = first_ts_q;
    assign first_vld  = first_vld_q;

endmodule

// File: tb/tb_axi_arb_chk.sv
// Directed bench for axi_arb_chk with a cycle-level reference model.
module tb_axi_arb_chk;
    import axi_arb_chk_pkg::*;

    localparam int NUM_CH   = 3;
    localparam int CNT_W    = 17;
    localparam int WEIGHT_W = 16;
    localparam int RR_MAX   = 2;
    localparam int STARVE_W = 12;
    localparam int TS_W     = 32;
    localparam int RUN_MAX  = (1 << CNT_W) - 1;
    localparam int WAIT_MAX = (1 << STARVE_W) - 1;

    logic                       aclk = 1'b0;
    logic                       areset_n;
    logic                       arb_en;
    logic [1:0]                 arb_mode;
    logic [NUM_CH*WEIGHT_W-1:0] weight;
    logic [STARVE_W-1:0]        starve_limit;
    logic [NUM_CH-1:0]          awvalid;
    logic [NUM_CH-1:0]          awready;
    logic                       clear_err;
    logic [7:0]                 err_status;
    logic                       err_any;
    logic                       err_irq;
    logic [2:0]                 first_code;
    logic [1:0]                 first_chan;
    logic [TS_W-1:0]            first_ts;
    logic                       first_vld;

    int n_checks = 0;
    int n_pass   = 0;
    int n_step   = 0;

    axi_arb_chk #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .WEIGHT_W (WEIGHT_W),
        .RR_MAX   (RR_MAX),
        .STARVE_W (STARVE_W),
        .TS_W     (TS_W)
    ) dut (
        .aclk         (aclk),
        .areset_n     (areset_n),
        .arb_en       (arb_en),
        .arb_mode     (arb_mode),
        .weight       (weight),
        .starve_limit (starve_limit),
        .awvalid      (awvalid),
        .awready      (awready),
        .clear_err    (clear_err),
        .err_status   (err_status),
        .err_any      (err_any),
        .err_irq      (err_irq),
        .first_code   (first_code),
        .first_chan   (first_chan),
        .first_ts     (first_ts),
        .first_vld    (first_vld)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          model_ok = 1'b0;
    logic [7:0]  m_status;
    bit          m_irq;
    int          m_code;
    int          m_chan;
    logic [31:0] m_fts;
    bit          m_vld;
    logic [31:0] m_ts;
    int          m_run    [NUM_CH];
    int          m_wait   [NUM_CH];
    bit          m_vprev  [NUM_CH];
    bit          m_hsprev [NUM_CH];

    always @(negedge aclk) begin : cmp
        logic [7:0] bits;
        int         ch_of [8];
        int         nhs;
        int         lowhs;
        int         code;
        bit         any_hs;
        bit         other_wait;
        bit         lower_valid;

        if (model_ok) begin
            check("err_status", err_status, m_status);
            check("err_any",    err_any,    (m_status != 8'h00));
            check("err_irq",    err_irq,    m_irq);
            check("first_code", first_code, m_code);
            check("first_chan", first_chan, m_chan);
            check("first_ts",   first_ts,   m_fts);
            check("first_vld",  first_vld,  m_vld);
        end

        if (!areset_n) begin
            m_status = '0; m_irq = 0; m_code = 0; m_chan = 0; m_fts = '0; m_vld = 0;
            m_ts = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_run[i] = 0; m_wait[i] = 0; m_vprev[i] = 0; m_hsprev[i] = 0;
            end
            model_ok = 1'b1;
        end else if (model_ok) begin
            bits = '0;
            for (int k = 0; k < 8; k++) ch_of[k] = 0;
            nhs = 0;
            lowhs = -1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (awvalid[i] && awready[i]) begin
                    nhs++;
                    if (lowhs < 0) lowhs = i;
                end
            end
            if (nhs > 1) begin bits[0] = 1; ch_of[0] = lowhs; end
            for (int j = 0; j < NUM_CH; j++) begin
                if (awvalid[j] && awready[j]) begin
                    other_wait = 0;
                    lower_valid = 0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (i != j && m_vprev[i]) other_wait = 1;
                        if (i < j && awvalid[i]) lower_valid = 1;
                    end
                    if (!arb_en && j != 0 && !bits[1]) begin bits[1] = 1; ch_of[1] = j; end
                    if (arb_en && arb_mode == 2'd0 && lower_valid && !bits[2]) begin
                        bits[2] = 1; ch_of[2] = j;
                    end
                    if (arb_en && arb_mode == 2'd1 && other_wait && m_run[j] >= RR_MAX && !bits[3]) begin
                        bits[3] = 1; ch_of[3] = j;
                    end
                    if (arb_en && arb_mode == 2'd2 && other_wait &&
                        m_run[j] > int'(weight[j*WEIGHT_W +: WEIGHT_W]) && !bits[4]) begin
                        bits[4] = 1; ch_of[4] = j;
                    end
                end
            end
            if (arb_en && arb_mode == 2'd3) bits[5] = 1;
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (starve_limit != 0 && m_wait[i] == int'(starve_limit)) begin
                    bits[6] = 1; ch_of[6] = i;
                end
                if (m_vprev[i] && !awvalid[i] && !m_hsprev[i]) begin
                    bits[7] = 1; ch_of[7] = i;
                end
            end
            code = 0;
            for (int k = 7; k >= 0; k--) if (bits[k]) code = k;

            m_irq = ((bits & ~m_status) != 8'h00);
            m_status = (clear_err ? 8'h00 : m_status) | bits;
            if ((!m_vld || clear_err) && bits != 8'h00) begin
                m_code = code; m_chan = ch_of[code]; m_fts = m_ts; m_vld = 1;
            end else if (clear_err) begin
                m_code = 0; m_chan = 0; m_fts = '0; m_vld = 0;
            end

            any_hs = (nhs > 0);
            for (int i = 0; i < NUM_CH; i++) begin
                if (awvalid[i] && awready[i] && arb_en) begin
                    if (m_run[i] < RUN_MAX) m_run[i]++;
                end else if (any_hs && !(awvalid[i] && awready[i])) begin
                    m_run[i] = 0;
                end else if (awvalid[i] && awready[i] && nhs > 1) begin
                    m_run[i] = 0;
                end
                if (awvalid[i] && !awready[i]) begin
                    if (m_wait[i] < WAIT_MAX) m_wait[i]++;
                end else begin
                    m_wait[i] = 0;
                end
                m_vprev[i]  = awvalid[i];
                m_hsprev[i] = awvalid[i] && awready[i];
            end
            m_ts = m_ts + 32'd1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] r);
        awvalid = v;
        awready = r;
        @(posedge aclk);
        #1;
        n_step++;
        $display("step %0d rst_n=%0d en=%0d mode=%0d v=%b r=%b clr=%0d -> status=%h irq=%0d code=%0d chan=%0d vld=%0d",
                 n_step, areset_n, arb_en, arb_mode, v, r, clear_err,
                 err_status, err_irq, first_code, first_chan, first_vld);
    endtask

    task automatic do_reset();
        arb_en = 1'b1;
        arb_mode = 2'd0;
        weight = '0;
        starve_limit = '0;
        clear_err = 1'b0;
        areset_n = 1'b0;
        step('0, '0);
        step('0, '0);
        areset_n = 1'b1;
    endtask

    initial begin
        areset_n = 1'b0;
        arb_en = 1'b1;
        arb_mode = 2'd0;
        weight = '0;
        starve_limit = '0;
        awvalid = '0;
        awready = '0;
        clear_err = 1'b0;

        // Reset state
        do_reset();
        check("reset_status", err_status, 8'h00);
        check("reset_vld", first_vld, 1'b0);
        check("reset_ts", first_ts, 32'h0);

        // Round-robin clean rotation
        arb_mode = 2'd1;
        for (int k = 0; k < 6; k++) begin
            step(3'b111, 3'b001 << (k % 3));
            check("rr_clean_irq", err_irq, 1'b0);
        end
        check("rr_clean_status", err_status, 8'h00);

        // Round-robin over-run on channel 0 while channel 1 waits
        do_reset();
        arb_mode = 2'd1;
        step(3'b011, 3'b000);
        step(3'b011, 3'b001);
        step(3'b011, 3'b001);
        check("rr_ok_2nd", err_status, 8'h00);
        step(3'b011, 3'b001);
        check("rr_over_status", err_status, 8'h08);
        check("rr_over_code", first_code, 3);
        check("rr_over_chan", first_chan, 0);
        check("rr_over_irq", err_irq, 1'b1);
        step(3'b011, 3'b000);
        check("rr_irq_once", err_irq, 1'b0);

        // Weighted over-run: weight 4 allows 5 consecutive grants
        do_reset();
        arb_mode = 2'd2;
        weight[15:0] = 16'd4;
        step(3'b101, 3'b000);
        for (int k = 0; k < 5; k++) step(3'b101, 3'b001);
        check("wrr_5th_legal", err_status, 8'h00);
        step(3'b101, 3'b001);
        check("wrr_6th_status", err_status, 8'h10);
        check("wrr_6th_code", first_code, 4);

        // Multi-grant, then clear together with a PROTO drop on channel 2
        do_reset();
        step(3'b110, 3'b110);
        check("multi_status", err_status, 8'h05);
        check("multi_code", first_code, 0);
        check("multi_chan", first_chan, 1);
        step(3'b100, 3'b000);
        clear_err = 1'b1;
        step(3'b000, 3'b000);
        clear_err = 1'b0;
        check("clr_proto_status", err_status, 8'h80);
        check("clr_proto_code", first_code, 7);
        check("clr_proto_chan", first_chan, 2);
        check("clr_proto_irq", err_irq, 1'b1);

        // Starvation on channel 2, then reserved mode
        do_reset();
        starve_limit = 12'd10;
        for (int k = 1; k <= 10; k++) step(3'b100, 3'b000);
        check("starve_early", err_status, 8'h00);
        step(3'b100, 3'b000);
        check("starve_status", err_status, 8'h40);
        check("starve_chan", first_chan, 2);
        check("starve_irq", err_irq, 1'b1);
        for (int k = 12; k <= 15; k++) step(3'b100, 3'b000);
        check("starve_once_irq", err_irq, 1'b0);
        arb_mode = 2'd3;
        step(3'b100, 3'b000);
        check("mode_status", err_status, 8'h60);
        check("mode_code_kept", first_code, 6);

        // Reset mid-burst
        do_reset();
        arb_mode = 2'd1;
        step(3'b011, 3'b000);
        for (int k = 0; k < 4; k++) step(3'b011, 3'b001);
        check("burst_err", err_status, 8'h08);
        areset_n = 1'b0;
        step(3'b011, 3'b001);
        areset_n = 1'b1;
        check("midrst_status", err_status, 8'h00);
        check("midrst_vld", first_vld, 1'b0);
        check("midrst_irq", err_irq, 1'b0);
        check("midrst_ts", first_ts, 32'h0);
        step(3'b011, 3'b001);
        check("postrst_1st", err_status, 8'h00);
        step(3'b011, 3'b001);
        check("postrst_2nd", err_status, 8'h00);

        // Arbitration disabled: only channel 0 may be granted
        do_reset();
        arb_en = 1'b0;
        step(3'b010, 3'b010);
        check("noarb_status", err_status, 8'h02);
        check("noarb_chan", first_chan, 1);
        step(3'b000, 3'b000);
        check("noarb_no_proto", err_status, 8'h02);

        @(negedge aclk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
